// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory arbiter.
// Pulled into the arbiter and its round-robin helper through their module headers.
package imem_pkg;

  localparam int DEFAULT_DEPTH = 1024;
  localparam int DEFAULT_AW    = 10;

  // addi x0, x0, 0 -- returned for fetches that must not touch memory.
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef enum logic {
    WIN_LOADER = 1'b0,
    WIN_FETCH  = 1'b1
  } winner_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter (fetch vs loader) for the RUN phase.
// The last-winner flag moves only on contention, so a lone requester never skews fairness.
module rr_arb2
  import imem_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req_fetch,
  input  logic req_ld,
  output logic gnt_fetch,
  output logic gnt_ld
);

  winner_t last_winner;
  logic    contend;

  assign contend = en & req_fetch & req_ld;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    gnt_fetch = 1'b0;
    gnt_ld    = 1'b0;
    if (en) begin
      if (contend) begin
        gnt_fetch = (last_winner == WIN_LOADER);
        gnt_ld    = (last_winner == WIN_FETCH);
      end else begin
        gnt_fetch = req_fetch;
        gnt_ld    = req_ld;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_winner <= WIN_LOADER;
    end else if (contend) begin
      last_winner <= gnt_fetch ? WIN_FETCH : WIN_LOADER;
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// Single-port owner of the instruction memory: boot-time loader streaming, then
// round-robin sharing between CPU fetch and loader patch writes.
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = DEFAULT_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_data,
  input  logic          ld_last,
  input  logic          fetch_req,
  input  logic [31:0]   fetch_addr,
  output logic          fetch_gnt,
  output logic          fetch_rvalid,
  output logic [31:0]   fetch_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic          boot_done,
  output logic          fetch_err
);

  state_t        state;
  state_t        state_nxt;
  logic          in_run;
  logic          arb_fetch;
  logic          arb_ld;
  logic          ld_acc;
  logic          fetch_bad;
  logic [29:0]   fetch_word;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] addr_nxt;
  logic          rd_pend;
  logic          rd_nop;

  assign in_run = (state == RUN);

  rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .en        (in_run),
    .req_fetch (fetch_req),
    .req_ld    (ld_valid),
    .gnt_fetch (arb_fetch),
    .gnt_ld    (arb_ld)
  );

  // A misaligned or out-of-range PC is still granted but never reaches the array.
  assign fetch_word = fetch_addr[31:2];
  assign fetch_bad  = (fetch_addr[1:0] != 2'b00) || ({2'b00, fetch_word} >= 32'(DEPTH));

  always_comb begin
    state_nxt = state;
    ld_ready  = 1'b0;
    fetch_gnt = 1'b0;
    unique case (state)
      BOOT: begin
        ld_ready = 1'b1;
        if (ld_valid && ld_last) state_nxt = RUN;
      end
      RUN: begin
        ld_ready  = arb_ld;
        fetch_gnt = arb_fetch;
      end
    endcase
  end

  assign ld_acc = ld_valid & ld_ready;

  always_comb begin
    addr_nxt = addr_q;
    if (ld_acc) begin
      addr_nxt = ld_addr;
    end else if (fetch_gnt && !fetch_bad) begin
      addr_nxt = fetch_addr[AW+1:2];
    end
  end

  // Port outputs are forced to their idle values while reset is held, so no write
  // can leak out during the reset cycle even with a beat on the loader side.
  assign mem_we    = rst & ld_acc;
  assign mem_wdata = (rst && ld_acc) ? ld_data : 32'h0;
  assign mem_addr  = rst ? addr_nxt : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= BOOT;
      addr_q    <= '0;
      rd_pend   <= 1'b0;
      rd_nop    <= 1'b0;
      fetch_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      addr_q  <= addr_nxt;
      rd_pend <= fetch_gnt;
      rd_nop  <= fetch_gnt & fetch_bad;
      if (fetch_gnt && fetch_bad) fetch_err <= 1'b1;
    end
  end

  assign boot_done    = in_run;
  assign fetch_rvalid = rd_pend;
  assign fetch_rdata  = !rd_pend ? 32'h0 : (rd_nop ? NOP_INSN : mem_rdata);

endmodule

// File: tb/tb_imem_arbiter.sv
// Randomized scoreboard bench for imem_arbiter: a cycle-level reference model predicts
// grants and fetch responses; a separate monitor checks every returned word.
module tb_imem_arbiter;
  import imem_pkg::*;

  localparam int DEPTH = 1024;
  localparam int AW    = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ld_valid = 1'b0;
  logic          ld_ready;
  logic [AW-1:0] ld_addr = '0;
  logic [31:0]   ld_data = '0;
  logic          ld_last = 1'b0;
  logic          fetch_req = 1'b0;
  logic [31:0]   fetch_addr = '0;
  logic          fetch_gnt;
  logic          fetch_rvalid;
  logic [31:0]   fetch_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = '0;
  logic          boot_done;
  logic          fetch_err;

  imem_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .ld_valid     (ld_valid),
    .ld_ready     (ld_ready),
    .ld_addr      (ld_addr),
    .ld_data      (ld_data),
    .ld_last      (ld_last),
    .fetch_req    (fetch_req),
    .fetch_addr   (fetch_addr),
    .fetch_gnt    (fetch_gnt),
    .fetch_rvalid (fetch_rvalid),
    .fetch_rdata  (fetch_rdata),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .boot_done    (boot_done),
    .fetch_err    (fetch_err)
  );

  always #5 clk = ~clk;

  // Synchronous-read word memory outside the block.
  logic [31:0] mem [DEPTH];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  // Reference model state: what the spec says memory, mode and fairness look like.
  logic [31:0]   ref_mem [DEPTH];
  bit            ref_run;
  bit            ref_last_loader;
  bit            ref_err;
  logic [AW-1:0] ref_addr;
  logic [31:0]   exp_q [$];
  bit            last_ld_acc;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic ref_reset();
    ref_run         = 1'b0;
    ref_last_loader = 1'b1;
    ref_err         = 1'b0;
    ref_addr        = '0;
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ld_ready"}, ld_ready, 1);
    check({tag, "_fetch_gnt"}, fetch_gnt, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_boot_done"}, boot_done, 0);
    check({tag, "_fetch_err"}, fetch_err, 0);
    check({tag, "_rvalid"}, fetch_rvalid, 0);
    check({tag, "_rdata"}, fetch_rdata, 0);
  endtask

  // One clock cycle: drive inputs, predict and check the port, then advance the model.
  task automatic step(input bit fv, input logic [31:0] fa, input bit lv,
                      input logic [AW-1:0] la, input logic [31:0] ld, input bit ll);
    bit eg_f, eg_l, bad, was_run;
    @(negedge clk);
    fetch_req = fv; fetch_addr = fa;
    ld_valid = lv; ld_addr = la; ld_data = ld; ld_last = ll;
    #1;
    check("boot_done", boot_done, ref_run);
    check("fetch_err", fetch_err, ref_err);
    bad     = (fa[1:0] != 2'b00) || ((fa >> 2) >= DEPTH);
    was_run = ref_run;
    if (!ref_run) begin
      eg_l = 1'b1;
      eg_f = 1'b0;
    end else begin
      eg_f = fv && (!lv || ref_last_loader);
      eg_l = lv && !eg_f;
    end
    check("ld_ready", ld_ready, eg_l);
    check("fetch_gnt", fetch_gnt, eg_f);
    check("mem_we", mem_we, lv && eg_l);
    if (lv && eg_l) begin
      check("mem_addr_wr", mem_addr, la);
      check("mem_wdata_wr", mem_wdata, ld);
      ref_addr = la;
    end else begin
      check("mem_wdata_idle", mem_wdata, 0);
      if (eg_f && !bad) ref_addr = fa[AW+1:2];
      check("mem_addr", mem_addr, ref_addr);
    end
    @(posedge clk);
    last_ld_acc = lv && eg_l;
    if (eg_f) begin
      exp_q.push_back(bad ? NOP_INSN : ref_mem[fa[AW+1:2]]);
      if (bad) ref_err = 1'b1;
    end
    if (lv && eg_l) begin
      ref_mem[la] = ld;
      if (!was_run && ll) ref_run = 1'b1;
    end
    if (was_run && fv && lv) ref_last_loader = eg_l;
  endtask

  // Monitor: any word due this cycle must be presented; otherwise the read port is quiet.
  initial begin
    logic [31:0] w;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        w = exp_q.pop_front();
        check("fetch_rvalid", fetch_rvalid, 1);
        check("fetch_rdata", fetch_rdata, w);
      end else begin
        check("rvalid_idle", fetch_rvalid, 0);
        check("rdata_idle", fetch_rdata, 0);
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] boot_img [7];
    logic [AW-1:0] cur_la;
    logic [31:0] cur_ld;
    logic [31:0] fa;
    boot_img[0] = 32'h0062E233; boot_img[1] = 32'h00B67433; boot_img[2] = 32'h00B60433;
    boot_img[3] = 32'h00C50533; boot_img[4] = 32'h00D585B3; boot_img[5] = 32'h00E60633;
    boot_img[6] = 32'h0004A483;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = 32'h0;
      ref_mem[i] = 32'h0;
    end
    ref_reset();

    // Reset with a loader beat present: nothing may be written.
    ld_valid = 1'b1; ld_addr = 10'd9; ld_data = 32'h1234_5678;
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("por");
    @(negedge clk);
    ld_valid = 1'b0;
    rst = 1'b1;

    // Boot load with fetch held the whole time; includes a non-accepted ld_last.
    step(1, 32'h0, 1, 10'd0, boot_img[0], 0);
    step(1, 32'h0, 0, 10'd0, 32'h0, 1);
    for (int i = 1; i < 6; i++) step(1, 32'h0, 1, AW'(i), boot_img[i], 0);
    step(1, 32'h0, 0, 10'd0, 32'h0, 0);
    step(1, 32'h0, 1, 10'd6, boot_img[6], 1);

    // First RUN cycle grants the held fetch; then a sequential stream.
    step(1, 32'h0, 0, 10'd0, 32'h0, 0);
    step(1, 32'h4, 0, 10'd0, 32'h0, 0);
    step(1, 32'h8, 0, 10'd0, 32'h0, 0);
    step(0, 32'h0, 0, 10'd0, 32'h0, 0);

    // Contention: fetch, loader, fetch (sees new word), loader.
    step(1, 32'h4, 1, 10'd1, 32'hDEADBEEF, 0);
    step(1, 32'h4, 1, 10'd1, 32'hDEADBEEF, 0);
    step(1, 32'h4, 1, 10'd2, 32'hCAFEF00D, 1);
    step(1, 32'h4, 1, 10'd2, 32'hCAFEF00D, 0);
    step(1, 32'h8, 0, 10'd0, 32'h0, 0);

    // Error fetches: misaligned, out of range, then a good one with the flag sticky.
    step(1, 32'h2, 0, 10'd0, 32'h0, 0);
    step(1, 32'h1000, 0, 10'd0, 32'h0, 0);
    step(1, 32'h0, 0, 10'd0, 32'h0, 0);
    step(0, 32'h0, 0, 10'd0, 32'h0, 0);

    // Randomized traffic over a small address window for read-after-write hits.
    cur_la = AW'($urandom_range(0, 31));
    cur_ld = $urandom;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) fa = $urandom;
      else fa = 32'($urandom_range(0, 31)) << 2;
      step($urandom_range(0, 1) == 1, fa, $urandom_range(0, 1) == 1, cur_la, cur_ld,
           $urandom_range(0, 3) == 0);
      if (last_ld_acc) begin
        cur_la = AW'($urandom_range(0, 31));
        cur_ld = $urandom;
      end
    end
    step(0, 32'h0, 0, 10'd0, 32'h0, 0);

    // Reset in the middle of a fetch grant: the read must vanish.
    @(negedge clk);
    fetch_req = 1'b1; fetch_addr = 32'h0; ld_valid = 1'b0;
    #1 check("midop_gnt", fetch_gnt, 1);
    #2 rst = 1'b0;
    #1 check_reset_outputs("midop");
    ref_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    fetch_req = 1'b0;
    rst = 1'b1;

    // Short reboot: memory contents survive; the patched word is fetched back.
    step(1, 32'h14, 1, 10'd5, 32'h00A00093, 1);
    step(1, 32'h14, 0, 10'd0, 32'h0, 0);
    step(1, 32'h4, 0, 10'd0, 32'h0, 0);
    step(0, 32'h0, 0, 10'd0, 32'h0, 0);
    step(0, 32'h0, 0, 10'd0, 32'h0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
